// File: rtl/wvb_overflow_mgr.sv
// wvb_overflow_mgr: waveform buffer fill tracking with throttle/overflow trigger gating
module wvb_overflow_mgr #(
  parameter int P_ADR_WIDTH = 12,
  parameter int P_CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [P_ADR_WIDTH-1:0] wvb_wr_addr,
  input  logic [P_ADR_WIDTH-1:0] stop_addr,
  input  logic                   wvb_rddone,
  input  logic                   hdr_full,
  input  logic [P_ADR_WIDTH-1:0] hi_thresh,
  input  logic [P_ADR_WIDTH-1:0] lo_thresh,
  input  logic                   trig_in,
  input  logic                   cnt_clr,
  output logic                   trig_out,
  output logic                   overflow,
  output logic                   throttle,
  output logic                   ovf_seen,
  output logic [15:0]            wvb_wused,
  output logic [P_CNT_WIDTH-1:0] n_dropped
);
  typedef enum logic [1:0] {S_OK, S_THROTTLE, S_OVF} state_t;
  state_t state, state_nxt;
  logic [P_ADR_WIDTH-1:0] last_rd_addr, used;
  logic full, drop;
  // occupancy is computed from the pre-update read pointer; wrap-around is intended
  assign used = wvb_wr_addr - (last_rd_addr + 1'b1);
  assign full = hdr_full | (wvb_wr_addr == last_rd_addr);
  assign drop = trig_in & (state != S_OK);
  // next-state: full always wins over the threshold comparisons
  always_comb begin
    state_nxt = state;
    if (full) state_nxt = S_OVF;
    else if (state == S_OK) state_nxt = (used >= hi_thresh) ? S_THROTTLE : S_OK;
    else state_nxt = (used <= lo_thresh) ? S_OK : S_THROTTLE;
  end
  // state, read pointer and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_OK;
      last_rd_addr <= '1;
      trig_out     <= 1'b0;
      overflow     <= 1'b0;
      throttle     <= 1'b0;
      ovf_seen     <= 1'b0;
      wvb_wused    <= '0;
      n_dropped    <= '0;
    end else begin
      state     <= state_nxt;
      if (wvb_rddone) last_rd_addr <= stop_addr;
      trig_out  <= trig_in & (state == S_OK);
      overflow  <= state_nxt == S_OVF;
      throttle  <= state_nxt != S_OK;
      wvb_wused <= 16'(used);
      if (state_nxt == S_OVF && state != S_OVF) ovf_seen <= 1'b1;
      else if (cnt_clr) ovf_seen <= 1'b0;
      if (cnt_clr) n_dropped <= '0;
      else if (drop && !(&n_dropped)) n_dropped <= n_dropped + 1'b1;
    end
  end
endmodule

// File: tb/tb_wvb_overflow_mgr.sv
// tb_wvb_overflow_mgr: directed-vector bench for the overflow manager
module tb_wvb_overflow_mgr;
  logic clk = 1'b0;
  logic rst_n;
  logic [11:0] wvb_wr_addr, stop_addr, hi_thresh, lo_thresh;
  logic wvb_rddone, hdr_full, trig_in, cnt_clr;
  logic trig_out, overflow, throttle, ovf_seen;
  logic [15:0] wvb_wused;
  logic [3:0] n_dropped;
  int vec = 0;
  int errs = 0;

  wvb_overflow_mgr #(.P_ADR_WIDTH(12), .P_CNT_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .wvb_wr_addr(wvb_wr_addr), .stop_addr(stop_addr),
    .wvb_rddone(wvb_rddone), .hdr_full(hdr_full), .hi_thresh(hi_thresh),
    .lo_thresh(lo_thresh), .trig_in(trig_in), .cnt_clr(cnt_clr), .trig_out(trig_out),
    .overflow(overflow), .throttle(throttle), .ovf_seen(ovf_seen),
    .wvb_wused(wvb_wused), .n_dropped(n_dropped)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; wvb_wr_addr = '0; stop_addr = '0; wvb_rddone = 0; hdr_full = 0;
    hi_thresh = 12'd3000; lo_thresh = 12'd1000; trig_in = 0; cnt_clr = 0;
    #2 rst_n = 1'b0;
    #10;
    vec++;
    if ({trig_out, overflow, throttle, ovf_seen, wvb_wused, n_dropped} !== '0) begin
      errs++; $display("FAIL reset_outputs got=%h exp=0", {trig_out, overflow, throttle, ovf_seen, wvb_wused, n_dropped});
    end
    @(negedge clk) rst_n = 1'b1;
    tick();
    vec++;
    if (wvb_wused !== 16'd0 || throttle !== 1'b0 || overflow !== 1'b0) begin
      errs++; $display("FAIL reset_wused0 wused=%0d thr=%b ovf=%b exp=0/0/0", wvb_wused, throttle, overflow);
    end
    wvb_wr_addr = 12'd100;
    tick();
    vec++;
    if (wvb_wused !== 16'd100) begin
      errs++; $display("FAIL wused100 got=%0d exp=100", wvb_wused);
    end
  endtask

  task automatic test_throttle();
    wvb_wr_addr = 12'd2500; trig_in = 1;
    tick();
    vec++;
    if (trig_out !== 1'b1 || throttle !== 1'b0) begin
      errs++; $display("FAIL trig_pass trig_out=%b thr=%b exp=1/0", trig_out, throttle);
    end
    wvb_wr_addr = 12'd3000;
    tick();
    vec++;
    if (throttle !== 1'b1 || trig_out !== 1'b1 || n_dropped !== 4'd0 || wvb_wused !== 16'd3000) begin
      errs++; $display("FAIL thr_enter thr=%b trig_out=%b nd=%0d wused=%0d exp=1/1/0/3000", throttle, trig_out, n_dropped, wvb_wused);
    end
    tick();
    vec++;
    if (trig_out !== 1'b0 || n_dropped !== 4'd1 || overflow !== 1'b0) begin
      errs++; $display("FAIL thr_block trig_out=%b nd=%0d ovf=%b exp=0/1/0", trig_out, n_dropped, overflow);
    end
    trig_in = 0; wvb_rddone = 1; stop_addr = 12'd2499;
    tick();
    vec++;
    if (throttle !== 1'b1 || wvb_wused !== 16'd3000) begin
      errs++; $display("FAIL rddone_preupdate thr=%b wused=%0d exp=1/3000", throttle, wvb_wused);
    end
    wvb_rddone = 0;
    tick();
    vec++;
    if (throttle !== 1'b0 || wvb_wused !== 16'd500) begin
      errs++; $display("FAIL thr_exit thr=%b wused=%0d exp=0/500", throttle, wvb_wused);
    end
  endtask

  task automatic test_overflow();
    hi_thresh = 12'hFFF; wvb_rddone = 1; stop_addr = 12'h7FF; wvb_wr_addr = 12'h7FF;
    tick();
    vec++;
    if (throttle !== 1'b0 || overflow !== 1'b0) begin
      errs++; $display("FAIL ovf_pre thr=%b ovf=%b exp=0/0", throttle, overflow);
    end
    wvb_rddone = 0;
    tick();
    vec++;
    if (overflow !== 1'b1 || throttle !== 1'b1 || ovf_seen !== 1'b1 || wvb_wused !== 16'hFFF) begin
      errs++; $display("FAIL ovf_enter ovf=%b thr=%b seen=%b wused=%h exp=1/1/1/fff", overflow, throttle, ovf_seen, wvb_wused);
    end
    wvb_rddone = 1; stop_addr = 12'h9FF;
    tick();
    wvb_rddone = 0; lo_thresh = 12'hFFF;
    tick();
    vec++;
    if (overflow !== 1'b0 || throttle !== 1'b0 || wvb_wused !== 16'hDFF || ovf_seen !== 1'b1) begin
      errs++; $display("FAIL ovf_exit ovf=%b thr=%b wused=%h seen=%b exp=0/0/dff/1", overflow, throttle, wvb_wused, ovf_seen);
    end
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    vec++;
    if (ovf_seen !== 1'b0 || n_dropped !== 4'd0) begin
      errs++; $display("FAIL clr seen=%b nd=%0d exp=0/0", ovf_seen, n_dropped);
    end
  endtask

  task automatic test_hdr_full();
    lo_thresh = 12'd1000; wvb_wr_addr = 12'hA05; hdr_full = 1;
    tick();
    vec++;
    if (overflow !== 1'b1 || wvb_wused !== 16'd5 || ovf_seen !== 1'b1) begin
      errs++; $display("FAIL hdr_full ovf=%b wused=%0d seen=%b exp=1/5/1", overflow, wvb_wused, ovf_seen);
    end
    for (int i = 1; i <= 3; i++) begin
      trig_in = 1;
      tick();
      trig_in = 0;
      tick();
      vec++;
      if (n_dropped !== 4'(i) || trig_out !== 1'b0) begin
        errs++; $display("FAIL drop_%0d nd=%0d trig_out=%b exp=%0d/0", i, n_dropped, trig_out, i);
      end
    end
  endtask

  task automatic test_saturation();
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    vec++;
    if (n_dropped !== 4'd0) begin
      errs++; $display("FAIL sat_clr nd=%0d exp=0", n_dropped);
    end
    trig_in = 1;
    repeat (20) tick();
    vec++;
    if (n_dropped !== 4'd15) begin
      errs++; $display("FAIL saturate nd=%0d exp=15", n_dropped);
    end
    cnt_clr = 1;
    tick();
    cnt_clr = 0; trig_in = 0;
    vec++;
    if (n_dropped !== 4'd0) begin
      errs++; $display("FAIL clr_beats_inc nd=%0d exp=0", n_dropped);
    end
  endtask

  task automatic test_async_reset();
    trig_in = 1;
    repeat (7) tick();
    trig_in = 0;
    vec++;
    if (n_dropped !== 4'd7 || overflow !== 1'b1) begin
      errs++; $display("FAIL pre_rst nd=%0d ovf=%b exp=7/1", n_dropped, overflow);
    end
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    vec++;
    if ({trig_out, overflow, throttle, ovf_seen, wvb_wused, n_dropped} !== '0) begin
      errs++; $display("FAIL async_rst got=%h exp=0", {trig_out, overflow, throttle, ovf_seen, wvb_wused, n_dropped});
    end
    hdr_full = 0; wvb_wr_addr = 12'd0;
    @(negedge clk) rst_n = 1'b1;
    tick();
    vec++;
    if (overflow !== 1'b0 || throttle !== 1'b0 || wvb_wused !== 16'd0) begin
      errs++; $display("FAIL post_rst ovf=%b thr=%b wused=%0d exp=0/0/0", overflow, throttle, wvb_wused);
    end
  endtask

  initial begin
    test_reset();
    test_throttle();
    test_overflow();
    test_hdr_full();
    test_saturation();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/wvb_overflow_mgr.md
WVB_OVERFLOW_MGR -- requirements
Module: wvb_overflow_mgr

Interface
REQ-001 SHALL provide parameter P_ADR_WIDTH, default 12, waveform buffer address width (valid 4..16).
REQ-002 SHALL provide parameter P_CNT_WIDTH, default 16, width of the dropped-trigger counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is in this domain.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port wvb_wr_addr, input, P_ADR_WIDTH, current buffer write address.
REQ-006 SHALL have port stop_addr, input, P_ADR_WIDTH, last written address of the event at the head of the header FIFO.
REQ-007 SHALL have port wvb_rddone, input, 1, one-cycle pulse when the head event has been fully read.
REQ-008 SHALL have port hdr_full, input, 1, header FIFO full.
REQ-009 SHALL have ports hi_thresh and lo_thresh, input, P_ADR_WIDTH each, throttle entry and exit levels in words.
REQ-010 SHALL have port trig_in, input, 1, trigger request from the discriminator.
REQ-011 SHALL have port cnt_clr, input, 1, clears the dropped counter and the sticky flag.
REQ-012 SHALL have port trig_out, output, 1, gated trigger.
REQ-013 SHALL have ports overflow, throttle and ovf_seen, output, 1 each, status flags.
REQ-014 SHALL have port wvb_wused, output, 16, words in use, zero-extended.
REQ-015 SHALL have port n_dropped, output, P_CNT_WIDTH, dropped-trigger count.

Function
REQ-016 SHALL hold last_rd_addr, loaded with stop_addr on each cycle where wvb_rddone=1.
REQ-017 SHALL compute used = (wvb_wr_addr - (last_rd_addr + 1)) mod 2^P_ADR_WIDTH; the wrap-around is intentional.
REQ-018 SHALL define full = hdr_full OR (wvb_wr_addr == last_rd_addr).
REQ-019 SHALL compute full, used and the state transitions from the current register values and inputs, and SHALL register all outputs, giving 1-cycle latency.
REQ-020 SHALL, when wvb_rddone and a threshold check fall in the same cycle, use the pre-update last_rd_addr for that cycle.
REQ-021 SHALL implement a three-state machine with states OK, THROTTLE and OVF.
REQ-022 SHALL move OK->OVF when full, and OK->THROTTLE when not full and used >= hi_thresh.
REQ-023 SHALL move THROTTLE->OVF when full, and THROTTLE->OK when not full and used <= lo_thresh.
REQ-024 SHALL move OVF->OK when not full and used <= lo_thresh, and OVF->THROTTLE when not full and used > lo_thresh.
REQ-025 SHALL give full priority over all threshold conditions; comparisons are unsigned with no check of lo_thresh < hi_thresh.
REQ-026 SHALL drive overflow=1 iff the registered state is OVF, and throttle=1 iff the state is not OK.
REQ-027 SHALL register trig_out = trig_in AND (current state == OK), evaluated before that edge's transition.
REQ-028 SHALL increment n_dropped when trig_in=1 and the current state is not OK, saturating at all-ones.
REQ-029 SHALL clear n_dropped to 0 on cnt_clr; clear beats increment when both occur in the same cycle.
REQ-030 SHALL set ovf_seen on the cycle the state enters OVF and clear it on cnt_clr; set beats clear when both occur in the same cycle.
REQ-031 SHALL register wvb_wused as the used value zero-extended to 16 bits.

Reset
REQ-032 SHALL, while rst_n=0, asynchronously force last_rd_addr to all-ones, state to OK, trig_out, overflow, throttle and ovf_seen to 0, wvb_wused to 0 and n_dropped to 0.
REQ-033 SHALL, on reset mid-operation, discard all in-flight status; rst_n is released synchronously by the system, and the first post-reset edge evaluates normally.

Verification
REQ-034 SHALL check: after reset, wr_addr=0 -> wused=0, state OK; then wr_addr=100 -> wused=100 one cycle later.
REQ-035 SHALL check, with hi=3000 and lo=1000: wr_addr ramps to 3000 -> throttle=1 and trig_out blocked; rddone with stop_addr=2499 -> used=500 -> throttle=0.
REQ-036 SHALL check: with last_rd_addr=0x7FF, wr_addr=0x7FF -> overflow=1 and ovf_seen=1; rddone with stop_addr=0x9FF, wr_addr=0x7FF -> used=0xDFF; with lo=0xFFF the state goes to OK.
REQ-037 SHALL check: hdr_full=1 while used=5 -> OVF, and each trig_in pulse increments n_dropped.
REQ-038 SHALL check, with P_CNT_WIDTH=4: 20 dropped triggers -> n_dropped=15; cnt_clr together with trig_in -> 0.
REQ-039 SHALL check: rst_n asserted in OVF with n_dropped=7 -> all outputs 0 immediately, with no clock edge.
